seq_pattern_gen: RTL
====================

// Module: seq_pattern_gen
// PURPOSE
//  Serial pattern transmitter: the source end of the serial bit stream consumed
//  by the "1010" sequence detector. It shifts a programmable WIDTH-bit pattern
//  out MSB-first, one bit per clock, for a requested number of frames.
//  Consecutive frames are separated by GAP_LEN idle bits. A start/busy/done
//  handshake lets a controller or bench drive the detector with known stimulus.
// PARAMETERS
//  WIDTH    4        pattern length in bits (>=2)
//  DEF_PAT  4'b1010  pattern register value after reset
//  GAP_LEN  2        idle (x=0) cycles between frames; 0 = back-to-back frames
//  REP_W    4        width of the repeat count
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low reset
//  load       in   1      write pat_in into the pattern register (IDLE only)
//  pat_in     in   WIDTH  new pattern value
//  start      in   1      begin transmission (IDLE only)
//  rep_n      in   REP_W  number of frames to send, sampled with start
//  abort      in   1      synchronous abort; return to IDLE, no done pulse
//  x          out  1      serial data, registered
//  valid      out  1      high while x carries a pattern bit
//  busy       out  1      high in every state except IDLE
//  done       out  1      one-cycle pulse after the last bit of the last frame
//  curs       out  2      current FSM state, for debug
// BEHAVIOUR
//  - Reset (asynchronous, reset=0): x=0, valid=0, busy=0, done=0, curs=IDLE,
//    pattern register = DEF_PAT, frame counter = 0, bit index = 0.
//  - States: IDLE=0, SEND=1, GAP=2, DONE=3.
//  - IDLE: load=1 copies pat_in into the pattern register. When start=1 and
//    rep_n!=0, latch rep_n and go to SEND. If start=1 and rep_n==0, ignore
//    start: stay in IDLE, no done pulse. If load and start are both high in the
//    same cycle, the new pat_in is the pattern that is sent.
//  - Latency: when start is sampled at edge T, the first bit (pattern[WIDTH-1])
//    appears on x with valid=1 after edge T+1. Each following edge shifts out
//    the next lower bit. Bit k of frame f is therefore valid after edge
//    T+1+f*(WIDTH+GAP_LEN)+k.
//  - SEND: after bit 0 is shown, the controller decrements the frame count.
//    If frames remain and GAP_LEN>0, go to GAP. If frames remain and
//    GAP_LEN==0, start the next frame's MSB directly. If no frames remain, go
//    to DONE.
//  - GAP: x=0, valid=0 for exactly GAP_LEN cycles, then go to SEND (MSB).
//    No gap is inserted after the last frame.
//  - DONE: done=1, x=0, valid=0 for one cycle, then go to IDLE (busy=0).
//  - While busy: load and start are ignored. The pattern register and the
//    latched count do not change.
//  - abort=1 in any state: the next state is IDLE, x=0, valid=0, and done is
//    not pulsed. The pattern register is kept. abort has priority over start.
//  - Reset asserted mid-frame: outputs clear immediately (asynchronously),
//    and the partial frame is discarded.
//  - Frame counter width is REP_W. Max rep_n = 2^REP_W-1. No wrap-around.
//  - curs is the registered state. Encodings 2'b00..2'b11 are all legal; the
//    default case branch goes to IDLE.
// TESTING
//  1 Reset, start with rep_n=1 (DEF_PAT=1010) -> x=1,0,1,0 with valid=1 after
//    edges T+1..T+4, done=1 after edge T+5, busy=0 after edge T+6.
//  2 Set rep_n=3, GAP_LEN=2 -> x = 1010 00 1010 00 1010, valid low only in the
//    gaps, exactly one done pulse; the chained detector z pulses 3 times.
//  3 Build with GAP_LEN=0, rep_n=2 -> x = 10101010 contiguous, valid high for
//    8 cycles; the detector z pulses once per 4 bits as its overlap rule
//    dictates.
//  4 load pat_in=0110 in IDLE, then start -> x = 0,1,1,0. Send load=1 with
//    pat_in=1111 while busy -> no effect, and the next frame is still 0110.
//  5 start with rep_n=0 -> busy stays 0, x=0, no done. Send start while busy
//    -> ignored, and the frame count is unchanged.
//  6 abort after the 2nd bit -> IDLE next cycle, no done. Assert reset
//    mid-frame -> all outputs 0 immediately, and the pattern returns to DEF_PAT.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial pattern transmitter, MSB-first, with inter-frame gaps
//   clk    in          rising-edge clock
//   reset  in          asynchronous active-low reset
//   load   in          write pat_in into the pattern register (IDLE only)
//   pat_in in  WIDTH   new pattern value
//   start  in          begin transmission (IDLE only, needs rep_n != 0)
//   rep_n  in  REP_W   number of frames, sampled with start
//   abort  in          synchronous abort back to IDLE without done
//   x      out         registered serial data
//   valid  out         x carries a pattern bit
//   busy   out         transmitter not idle
//   done   out         one-cycle pulse after the last frame
//   curs   out 2       current state (debug)
module seq_pattern_gen #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] DEF_PAT = 4'b1010,
    parameter int               GAP_LEN = 2,
    parameter int               REP_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] pat_in,
    input  logic             start,
    input  logic [REP_W-1:0] rep_n,
    input  logic             abort,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       curs
);
    localparam int IW = $clog2(WIDTH);
    localparam int GW = GAP_LEN > 1 ? $clog2(GAP_LEN) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2, DONE = 2'd3} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] pat, pat_d;
    logic [REP_W-1:0] cnt, cnt_d;
    logic [IW-1:0]    idx, idx_d;
    logic [GW-1:0]    gcnt, gcnt_d;
    logic             x_d, valid_d, done_d;

    // Outputs are computed from the current state and registered, so they
    // trail the state register by one cycle; busy is delayed to match.
    always_comb begin
        state_d = state;
        pat_d   = pat;
        cnt_d   = cnt;
        idx_d   = idx;
        gcnt_d  = gcnt;
        x_d     = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (!abort) begin
                    if (load) pat_d = pat_in;
                    if (start && rep_n != '0) begin
                        state_d = SEND;
                        cnt_d   = rep_n;
                        idx_d   = IW'(WIDTH - 1);
                    end
                end
            end
            SEND: begin
                x_d     = pat[idx];
                valid_d = 1'b1;
                idx_d   = idx - IW'(1);
                if (idx == '0) begin
                    cnt_d = cnt - REP_W'(1);
                    idx_d = IW'(WIDTH - 1);
                    if (cnt == REP_W'(1)) state_d = DONE;
                    else if (GAP_LEN > 0) begin
                        state_d = GAP;
                        gcnt_d  = GW'(GAP_LEN - 1);
                    end
                end
            end
            GAP: begin
                if (gcnt == '0) state_d = SEND;
                gcnt_d = gcnt - GW'(1);
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            x_d     = 1'b0;
            valid_d = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pat   <= DEF_PAT;
            cnt   <= '0;
            idx   <= '0;
            gcnt  <= '0;
            x     <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            pat   <= pat_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            gcnt  <= gcnt_d;
            x     <= x_d;
            valid <= valid_d;
            busy  <= state != IDLE && !abort;
            done  <= done_d;
        end
    end

    assign curs = state;
endmodule
